// File: rtl/match_scanner.sv
// match_scanner: scans a snapshot of an 8x8 board of 3-bit cells for
// horizontal and vertical runs of MIN_RUN equal non-empty cells, one
// cell index per clock, and reports the union of all matching cells.
//
// Optional feature: define MATCH_SCORE_EN to build a saturating score
// accumulator that adds match_count at the end of every scan. Without
// the macro, score is tied to zero and no accumulator is built.
module match_scanner #(
  parameter int MIN_RUN = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [191:0] board_flat,
  output logic         busy,
  output logic         done,
  output logic [63:0]  match_mask,
  output logic [6:0]   match_count,
  output logic         match_found,
  output logic [15:0]  score
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [191:0]  snap;
  logic [5:0]    idx;
  logic [63:0]   hits;
  logic [63:0]   mask_next;
  logic [6:0]    count_next;
  logic          last_cell;

  // Cell (r,c) of a flattened board.
  function automatic logic [2:0] cell_at(input logic [191:0] b,
                                         input int r, input int c);
    return b[8'((r * 8 + c) * 3) +: 3];
  endfunction

  // Number of set bits in a 64-bit mask.
  function automatic logic [6:0] popcount64(input logic [63:0] m);
    logic [6:0] n;
    n = '0;
    for (int i = 0; i < 64; i++) begin
      n = n + {6'd0, m[i]};
    end
    return n;
  endfunction

  // Unsigned add that clamps at the 16-bit ceiling instead of wrapping.
  function automatic logic [15:0] sat_add16(input logic [15:0] a,
                                            input logic [6:0]  b);
    logic [16:0] s;
    s = {1'b0, a} + {10'd0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  // Run detection anchored at the current cell: a run of MIN_RUN going
  // right and one going down, both checked in the same cycle. Longer and
  // overlapping runs fall out of the OR across successive anchors.
  always_comb begin : hit_calc
    int         r;
    int         c;
    logic [2:0] base;
    logic       h_eq;
    logic       v_eq;
    hits = '0;
    r    = int'(idx[5:3]);
    c    = int'(idx[2:0]);
    base = cell_at(snap, r, c);
    h_eq = (base != 3'd0) && (c + MIN_RUN <= 8);
    v_eq = (base != 3'd0) && (r + MIN_RUN <= 8);
    for (int k = 1; k < MIN_RUN; k++) begin
      if (c + k < 8) begin
        if (cell_at(snap, r, c + k) != base) h_eq = 1'b0;
      end
      if (r + k < 8) begin
        if (cell_at(snap, r + k, c) != base) v_eq = 1'b0;
      end
    end
    for (int k = 0; k < MIN_RUN; k++) begin
      if (h_eq && (c + k < 8)) hits[6'(r * 8 + c + k)] = 1'b1;
      if (v_eq && (r + k < 8)) hits[6'((r + k) * 8 + c)] = 1'b1;
    end
  end

  assign mask_next  = match_mask | hits;
  assign count_next = popcount64(mask_next);
  assign last_cell  = (state == SCAN) && (idx == 6'd63);

  // Board snapshot taken when a scan is accepted; pure data, no reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) snap <= board_flat;
  end

  // Scan controller: IDLE -> SCAN (64 cells) -> DONE (one cycle) -> IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      match_mask  <= '0;
      match_count <= '0;
      match_found <= 1'b0;
      idx         <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            match_mask <= '0;
            idx        <= '0;
            busy       <= 1'b1;
            state      <= SCAN;
          end
        end
        SCAN: begin
          match_mask <= mask_next;
          idx        <= idx + 6'd1;
          if (idx == 6'd63) begin
            busy        <= 1'b0;
            done        <= 1'b1;
            match_count <= count_next;
            match_found <= |mask_next;
            state       <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef MATCH_SCORE_EN
  // Running score: add the final count of each scan, clamped at 16'hFFFF.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      score <= '0;
    end else if (last_cell) begin
      score <= sat_add16(score, count_next);
    end
  end
`else
  assign score = '0;
  logic unused_score_inputs;
  assign unused_score_inputs = last_cell;
`endif

endmodule

// File: tb/tb_match_scanner.sv
// Bench for match_scanner: directed boards from the requirement list plus
// random boards, checked against a run-length reference model.
module tb_match_scanner;

  localparam int MIN_RUN = 3;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [191:0] board_flat;
  logic         busy;
  logic         done;
  logic [63:0]  match_mask;
  logic [6:0]   match_count;
  logic         match_found;
  logic [15:0]  score;

  int tests = 0;
  int fails = 0;
  int score_m = 0;

  match_scanner #(.MIN_RUN(MIN_RUN)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .board_flat  (board_flat),
    .busy        (busy),
    .done        (done),
    .match_mask  (match_mask),
    .match_count (match_count),
    .match_found (match_found),
    .score       (score)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [191:0] put(input logic [191:0] b, input int r,
                                       input int c, input int v);
    logic [191:0] o;
    o = b;
    o[(r * 8 + c) * 3 +: 3] = 3'(v);
    return o;
  endfunction

  function automatic int get(input logic [191:0] b, input int r, input int c);
    return int'(b[(r * 8 + c) * 3 +: 3]);
  endfunction

  function automatic logic [191:0] checker_board();
    logic [191:0] b;
    b = '0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        b = put(b, r, c, ((r + c) % 2) + 1);
    return b;
  endfunction

  // Reference: split every row and column into maximal runs of equal
  // values; a non-empty run of length >= MIN_RUN marks all its cells.
  function automatic logic [63:0] ref_mask(input logic [191:0] b);
    logic [63:0] m;
    int s;
    m = '0;
    for (int line = 0; line < 8; line++) begin
      s = 0;
      for (int p = 1; p <= 8; p++) begin
        if (p == 8 || get(b, line, p) != get(b, line, s)) begin
          if (get(b, line, s) != 0 && p - s >= MIN_RUN)
            for (int q = s; q < p; q++) m[line * 8 + q] = 1'b1;
          s = p;
        end
      end
      s = 0;
      for (int p = 1; p <= 8; p++) begin
        if (p == 8 || get(b, p, line) != get(b, s, line)) begin
          if (get(b, s, line) != 0 && p - s >= MIN_RUN)
            for (int q = s; q < p; q++) m[q * 8 + line] = 1'b1;
          s = p;
        end
      end
    end
    return m;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_busy"},  64'(busy), 64'd0);
    check({tag, "_done"},  64'(done), 64'd0);
    check({tag, "_mask"},  match_mask, 64'd0);
    check({tag, "_count"}, 64'(match_count), 64'd0);
    check({tag, "_found"}, 64'(match_found), 64'd0);
    check({tag, "_score"}, 64'(score), 64'd0);
  endtask

  // One complete scan. exp_cnt >= 0 additionally pins the count to a
  // hand-derived constant. disturb re-asserts start and scrambles the
  // board mid-scan; neither may affect the result.
  task automatic run_scan(input string tag, input logic [191:0] b,
                          input int exp_cnt, input bit disturb);
    logic [63:0] em;
    int cyc;
    em = ref_mask(b);
    board_flat = b;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_busy_on"}, 64'(busy), 64'd1);
    cyc = 0;
    while (!done && cyc < 100) begin
      if (disturb && cyc == 10) begin
        start = 1'b1;
        board_flat = ~b;
      end
      if (disturb && cyc == 12) start = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    board_flat = b;
    check({tag, "_latency"}, 64'(cyc), 64'd64);
    check({tag, "_busy_done"}, 64'(busy), 64'd0);
    check({tag, "_mask"}, match_mask, em);
    check({tag, "_count"}, 64'(match_count), 64'($countones(em)));
    check({tag, "_found"}, 64'(match_found), 64'(em != 64'd0));
    if (exp_cnt >= 0) check({tag, "_count_const"}, 64'(match_count), 64'(exp_cnt));
`ifdef MATCH_SCORE_EN
    score_m = score_m + $countones(em);
    if (score_m > 65535) score_m = 65535;
`endif
    check({tag, "_score"}, 64'(score), 64'(score_m));
    @(posedge clk); #1;
    check({tag, "_done_single"}, 64'(done), 64'd0);
    check({tag, "_hold_mask"}, match_mask, em);
    @(posedge clk); #1;
    check({tag, "_no_second_done"}, 64'(done), 64'd0);
  endtask

  initial begin : stimulus
    logic [191:0] b;
    logic [191:0] cb;
    int cyc;
    rst_n = 1'b0;
    start = 1'b0;
    board_flat = '0;
    #3;
    check_idle_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    cb = checker_board();
    run_scan("checker", cb, 0, 1'b0);

    b = cb;
    b = put(b, 0, 0, 3); b = put(b, 0, 1, 3); b = put(b, 0, 2, 3);
    b = put(b, 0, 3, 1); b = put(b, 0, 4, 2); b = put(b, 0, 5, 1);
    b = put(b, 0, 6, 2); b = put(b, 0, 7, 1);
    run_scan("row0_333", b, 3, 1'b0);
    check("row0_333_mask_const", match_mask, 64'h7);

    b = cb;
    for (int r = 0; r < 8; r++) b = put(b, r, 7, 5);
    run_scan("col7", b, 8, 1'b0);
    check("col7_mask_const", match_mask, 64'h8080_8080_8080_8080);

    b = cb;
    b = put(b, 0, 0, 4); b = put(b, 0, 1, 4); b = put(b, 0, 2, 4);
    b = put(b, 1, 0, 4); b = put(b, 2, 0, 4);
    run_scan("lshape", b, 5, 1'b0);

    b = cb;
    for (int c = 0; c < 8; c++) b = put(b, 0, c, 0);
    run_scan("row0_empty", b, 0, 1'b0);

    b = cb;
    for (int c = 2; c < 6; c++) b = put(b, 3, c, 7);
    run_scan("colour7_run4", b, 4, 1'b1);

    for (int t = 0; t < 4; t++) begin
      b = '0;
      for (int i = 0; i < 64; i++) b = put(b, i / 8, i % 8, int'($urandom_range(0, 3)));
      run_scan($sformatf("rand%0d", t), b, -1, (t % 2) == 1);
    end

    // Abort a scan with reset at scan cycle 30.
    b = cb;
    for (int r = 0; r < 8; r++) b = put(b, r, 7, 5);
    board_flat = b;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
    end
    check("abort_busy_before", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check_idle_zero("abort");
    score_m = 0;
    cyc = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) cyc++;
    end
    check("abort_no_done", 64'(cyc), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_idle_zero("after_abort");
    run_scan("after_abort_scan", b, 8, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
